// File: rtl/turbo_pkg.sv
// Shared constants and types for the LTE turbo-encoder block scheduler.
package turbo_pkg;

    localparam int K_SMALL  = 1056;
    localparam int K_LARGE  = 6144;
    localparam int F1_SMALL = 17;
    localparam int F2_SMALL = 66;
    localparam int F1_LARGE = 263;
    localparam int F2_LARGE = 480;
    localparam int TAIL_LEN = 3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ENC   = 3'd1,
        S_TAIL  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } tsched_state_t;

    // One slot of the encoder-facing strobe delay line.
    typedef struct packed {
        logic       data_ready;
        logic       bit_vld;
        logic       tail;
        logic [1:0] tail_idx;
    } enc_strobe_t;

endpackage

// File: rtl/qpp_addr_gen.sv
// Multiplier-free QPP interleaver address generator: pi(i+1)=pi(i)+g(i), g(i+1)=g(i)+2*f2, all mod K.
module qpp_addr_gen
    import turbo_pkg::*;
#(
    parameter int AW = 13
) (
    input  logic          clk,
    input  logic          aclr_n,
    input  logic          load,
    input  logic          step,
    input  logic          k_sel,
    output logic [AW-1:0] pi
);

    localparam logic [AW:0]   K_S  = (AW+1)'(K_SMALL);
    localparam logic [AW:0]   K_L  = (AW+1)'(K_LARGE);
    localparam logic [AW-1:0] G0_S = AW'((F1_SMALL + F2_SMALL) % K_SMALL);
    localparam logic [AW-1:0] G0_L = AW'((F1_LARGE + F2_LARGE) % K_LARGE);
    localparam logic [AW-1:0] D_S  = AW'((2 * F2_SMALL) % K_SMALL);
    localparam logic [AW-1:0] D_L  = AW'((2 * F2_LARGE) % K_LARGE);

    logic [AW-1:0] pi_r;
    logic [AW-1:0] g_r;
    logic [AW:0]   k_mod_s;
    logic [AW-1:0] g_inc_s;

    // Both operands are already reduced, so one conditional subtract suffices.
    function automatic logic [AW-1:0] mod_add(input logic [AW-1:0] a,
                                              input logic [AW-1:0] b,
                                              input logic [AW:0]   k);
        logic [AW:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= k) begin
            sum = sum - k;
        end else begin
            sum = sum;
        end
        return sum[AW-1:0];
    endfunction

    assign k_mod_s = k_sel ? K_L : K_S;
    assign g_inc_s = k_sel ? D_L : D_S;

    // pi/g recursion registers
    always_ff @(posedge clk) begin
        if (!aclr_n) begin
            pi_r <= {AW{1'b0}};
            g_r  <= {AW{1'b0}};
        end else if (load) begin
            pi_r <= {AW{1'b0}};
            g_r  <= k_sel ? G0_L : G0_S;
        end else if (step) begin
            pi_r <= mod_add(pi_r, g_r, k_mod_s);
            g_r  <= mod_add(g_r, g_inc_s, k_mod_s);
        end
    end

    assign pi = pi_r;

endmodule

// File: rtl/turbo_enc_sched.sv
// LTE turbo-encoder block scheduler: natural/QPP read addressing, encoder strobes and trellis termination.
// Optional feature macro TSCHED_OVERRUN_EN adds the overrun flag and ovr_cnt start-while-busy counter.
module turbo_enc_sched
    import turbo_pkg::*;
#(
    parameter int AW     = 13,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          aclr_n,
    input  logic          start,
    input  logic          k_sel,
    input  logic          abort,
    output logic          rd_en,
    output logic [AW-1:0] addr_nat,
    output logic [AW-1:0] addr_int,
    output logic          enc_data_ready,
    output logic          enc_bit_vld,
    output logic          enc_tail,
    output logic [1:0]    tail_idx,
    output logic          busy,
    output logic          done
`ifdef TSCHED_OVERRUN_EN
    ,
    output logic          overrun,
    output logic [7:0]    ovr_cnt
`endif
);

    localparam logic [7:0] TAIL_LAST  = 8'(TAIL_LEN - 1);
    localparam logic [7:0] DRAIN_LAST = (RD_LAT > 0) ? 8'(RD_LAT - 1) : 8'd0;

    tsched_state_t state_r;
    tsched_state_t state_nxt;
    logic [7:0]    phase_r;
    logic [7:0]    phase_nxt;
    logic [AW-1:0] idx_r;
    logic [AW-1:0] k_last_s;
    logic          k_sel_r;
    logic          k_cur_s;
    logic          start_acc_s;
    logic          step_s;
    logic          rd_en_r;
    logic          tail_r;
    logic [1:0]    tidx_r;
    logic          busy_r;
    logic          done_r;
    enc_strobe_t   cur_s;
    enc_strobe_t   out_s;

    assign k_last_s    = k_sel_r ? AW'(K_LARGE - 1) : AW'(K_SMALL - 1);
    assign start_acc_s = (state_r == S_IDLE) && (state_nxt == S_ENC);
    assign step_s      = (state_r == S_ENC) && (state_nxt == S_ENC);
    // The block size comes straight from the input on the accepting cycle, from the latch afterwards.
    assign k_cur_s     = start_acc_s ? k_sel : k_sel_r;

    // Next-state logic; abort overrides every state
    always_comb begin
        state_nxt = state_r;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE:  state_nxt = start ? S_ENC : S_IDLE;
                S_ENC:   state_nxt = (idx_r == k_last_s) ? S_TAIL : S_ENC;
                S_TAIL: begin
                    if (phase_r == TAIL_LAST) begin
                        state_nxt = (RD_LAT == 0) ? S_DONE : S_DRAIN;
                    end else begin
                        state_nxt = S_TAIL;
                    end
                end
                S_DRAIN: state_nxt = (phase_r == DRAIN_LAST) ? S_DONE : S_DRAIN;
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Per-state cycle counter for TAIL and DRAIN
    always_comb begin
        phase_nxt = 8'd0;
        if ((state_nxt == state_r) && ((state_r == S_TAIL) || (state_r == S_DRAIN))) begin
            phase_nxt = phase_r + 8'd1;
        end else begin
            phase_nxt = 8'd0;
        end
    end

    // FSM, index counter and undelayed strobe registers
    always_ff @(posedge clk) begin
        if (!aclr_n) begin
            state_r <= S_IDLE;
            phase_r <= 8'd0;
            idx_r   <= {AW{1'b0}};
            k_sel_r <= 1'b0;
            rd_en_r <= 1'b0;
            tail_r  <= 1'b0;
            tidx_r  <= 2'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt;
            phase_r <= phase_nxt;
            idx_r   <= step_s ? (idx_r + AW'(1)) : {AW{1'b0}};
            k_sel_r <= k_cur_s;
            rd_en_r <= (state_nxt == S_ENC);
            tail_r  <= (state_nxt == S_TAIL);
            tidx_r  <= (state_nxt == S_TAIL) ? phase_nxt[1:0] : 2'd0;
            busy_r  <= (state_nxt != S_IDLE);
            done_r  <= (state_nxt == S_DONE);
        end
    end

    qpp_addr_gen #(.AW(AW)) u_qpp (
        .clk    (clk),
        .aclr_n (aclr_n),
        .load   (start_acc_s),
        .step   (step_s),
        .k_sel  (k_cur_s),
        .pi     (addr_int)
    );

    assign cur_s = {rd_en_r && (idx_r == {AW{1'b0}}), rd_en_r, tail_r, tidx_r};

    // Strobes track the buffer read latency so they line up with the returned data.
    generate
        if (RD_LAT == 0) begin : g_nodly
            assign out_s = cur_s;
        end else begin : g_dly
            enc_strobe_t dly_r [RD_LAT];

            // Strobe delay line, flushed on abort
            always_ff @(posedge clk) begin
                if (!aclr_n || abort) begin
                    for (int j = 0; j < RD_LAT; j++) begin
                        dly_r[j] <= '{default: 1'b0};
                    end
                end else begin
                    dly_r[0] <= cur_s;
                    for (int j = 1; j < RD_LAT; j++) begin
                        dly_r[j] <= dly_r[j-1];
                    end
                end
            end

            assign out_s = dly_r[RD_LAT-1];
        end
    endgenerate

    assign rd_en          = rd_en_r;
    assign addr_nat       = idx_r;
    assign enc_data_ready = out_s.data_ready;
    assign enc_bit_vld    = out_s.bit_vld;
    assign enc_tail       = out_s.tail;
    assign tail_idx       = out_s.tail_idx;
    assign busy           = busy_r;
    assign done           = done_r;

`ifdef TSCHED_OVERRUN_EN
    logic       overrun_r;
    logic [7:0] ovr_cnt_r;

    // Sticky overrun flag and saturating count of starts seen while busy
    always_ff @(posedge clk) begin
        if (!aclr_n) begin
            overrun_r <= 1'b0;
            ovr_cnt_r <= 8'd0;
        end else if (start && busy_r) begin
            overrun_r <= 1'b1;
            ovr_cnt_r <= (ovr_cnt_r != 8'hFF) ? (ovr_cnt_r + 8'd1) : ovr_cnt_r;
        end
    end

    assign overrun = overrun_r;
    assign ovr_cnt = ovr_cnt_r;
`endif

endmodule

// File: tb/tb_turbo_enc_sched.sv
// Self-checking bench for turbo_enc_sched: closed-form QPP model, spec-derived cycle timing, known-value table.
module tb_turbo_enc_sched;

    localparam int AW     = 13;
    localparam int RD_LAT = 1;

    logic          clk = 1'b0;
    logic          aclr_n;
    logic          start;
    logic          k_sel;
    logic          abort;
    logic          rd_en;
    logic [AW-1:0] addr_nat;
    logic [AW-1:0] addr_int;
    logic          enc_data_ready;
    logic          enc_bit_vld;
    logic          enc_tail;
    logic [1:0]    tail_idx;
    logic          busy;
    logic          done;
`ifdef TSCHED_OVERRUN_EN
    logic          overrun;
    logic [7:0]    ovr_cnt;
`endif

    turbo_enc_sched #(.AW(AW), .RD_LAT(RD_LAT)) dut (
        .clk            (clk),
        .aclr_n         (aclr_n),
        .start          (start),
        .k_sel          (k_sel),
        .abort          (abort),
        .rd_en          (rd_en),
        .addr_nat       (addr_nat),
        .addr_int       (addr_int),
        .enc_data_ready (enc_data_ready),
        .enc_bit_vld    (enc_bit_vld),
        .enc_tail       (enc_tail),
        .tail_idx       (tail_idx),
        .busy           (busy),
        .done           (done)
`ifdef TSCHED_OVERRUN_EN
        ,
        .overrun        (overrun),
        .ovr_cnt        (ovr_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic ks;
        int   idx;
        int   exp_int;
    } vec_t;
    vec_t vt[9];

    string  sname[9] = '{"rd_en", "addr_nat", "addr_int", "enc_data_ready", "enc_bit_vld",
                         "enc_tail", "tail_idx", "busy", "done"};
    int     err[9];
    int     bad_c[9];
    longint bad_act[9];
    longint bad_exp[9];
    int     cap[6144];
    int     seen[6144];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic void cmp(input int s, input int c, input longint act, input longint exp);
        if (act != exp) begin
            if (err[s] == 0) begin
                bad_c[s]   = c;
                bad_act[s] = act;
                bad_exp[s] = exp;
            end
            err[s]++;
        end
    endfunction

    // Closed-form QPP, straight from pi(i) = (f1*i + f2*i^2) mod K
    function automatic int qpp_ref(input logic ks, input int i);
        longint k, f1, f2, li;
        k  = ks ? 64'd6144 : 64'd1056;
        f1 = ks ? 64'd263  : 64'd17;
        f2 = ks ? 64'd480  : 64'd66;
        li = i;
        return int'((f1 * li + f2 * li * li) % k);
    endfunction

    task automatic all_zero(input string tag);
        chk({tag, " rd_en"}, rd_en, 0);
        chk({tag, " addr_nat"}, addr_nat, 0);
        chk({tag, " addr_int"}, addr_int, 0);
        chk({tag, " enc_data_ready"}, enc_data_ready, 0);
        chk({tag, " enc_bit_vld"}, enc_bit_vld, 0);
        chk({tag, " enc_tail"}, enc_tail, 0);
        chk({tag, " tail_idx"}, tail_idx, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " done"}, done, 0);
`ifdef TSCHED_OVERRUN_EN
        chk({tag, " overrun"}, overrun, 0);
        chk({tag, " ovr_cnt"}, ovr_cnt, 0);
`endif
    endtask

    // One full block started in the next cycle, every output compared each cycle against the timing rules
    task automatic run_block(input logic ks, input bit extra, input bit rnd, input int trail);
        int k, kdone, rd_cnt, vld_cnt, dr_cnt, done_cnt, ovl, dup, miss, ti;
        bit e_rd, e_vld, e_tail;
        k = ks ? 6144 : 1056;
        kdone = k + 4 + RD_LAT;
        rd_cnt = 0; vld_cnt = 0; dr_cnt = 0; done_cnt = 0; ovl = 0; dup = 0; miss = 0;
        for (int s = 0; s < 9; s++) err[s] = 0;
        for (int i = 0; i < 6144; i++) begin
            cap[i]  = -1;
            seen[i] = 0;
        end
        tick();
        start = 1'b1;
        k_sel = ks;
        abort = 1'b0;
        for (int c = 1; c <= kdone + trail; c++) begin
            tick();
            e_rd   = (c <= k);
            e_vld  = (c >= 1 + RD_LAT) && (c <= k + RD_LAT);
            e_tail = (c >= k + 1 + RD_LAT) && (c <= k + 3 + RD_LAT);
            ti     = e_tail ? (c - (k + 1 + RD_LAT)) : 0;
            cmp(0, c, rd_en, e_rd);
            if (e_rd) begin
                cmp(1, c, addr_nat, c - 1);
                cmp(2, c, addr_int, qpp_ref(ks, c - 1));
                cap[c-1] = int'(addr_int);
            end
            cmp(3, c, enc_data_ready, (c == 1 + RD_LAT));
            cmp(4, c, enc_bit_vld, e_vld);
            cmp(5, c, enc_tail, e_tail);
            cmp(6, c, tail_idx, ti);
            cmp(7, c, busy, (c <= kdone));
            cmp(8, c, done, (c == kdone));
            if (rd_en) begin
                rd_cnt++;
                if (int'(addr_int) < k) begin
                    if (seen[addr_int] != 0) dup++;
                    seen[addr_int] = 1;
                end
            end
            vld_cnt  += int'(enc_bit_vld);
            dr_cnt   += int'(enc_data_ready);
            done_cnt += int'(done);
            if (enc_bit_vld && enc_tail) ovl++;
            start = 1'b0;
            if (extra && ((c == 501) || (c == kdone))) start = 1'b1;
            if (rnd && (c <= kdone) && ($urandom_range(0, 63) == 0)) start = 1'b1;
            k_sel = rnd ? 1'($urandom) : ks;
        end
        start = 1'b0;
        for (int s = 0; s < 9; s++) begin
            checks++;
            if (err[s] != 0) begin
                failures++;
                $display("FAIL blk k=%0d %s: %0d bad cycles, first c=%0d got %0d expected %0d",
                         k, sname[s], err[s], bad_c[s], bad_act[s], bad_exp[s]);
            end
        end
        for (int i = 0; i < k; i++) if (seen[i] == 0) miss++;
        chk($sformatf("rd_en count k=%0d", k), rd_cnt, k);
        chk($sformatf("bit_vld count k=%0d", k), vld_cnt, k);
        chk($sformatf("data_ready pulses k=%0d", k), dr_cnt, 1);
        chk($sformatf("done pulses k=%0d", k), done_cnt, 1);
        chk($sformatf("vld/tail overlap k=%0d", k), ovl, 0);
        chk($sformatf("perm missing k=%0d", k), miss, 0);
        chk($sformatf("perm dup k=%0d", k), dup, 0);
        for (int v = 0; v < 9; v++) begin
            if (vt[v].ks == ks) chk($sformatf("qpp k=%0d i=%0d", k, vt[v].idx), cap[vt[v].idx], vt[v].exp_int);
        end
    endtask

    initial begin
        int dcnt, bcnt;
        aclr_n = 1'b0;
        start  = 1'b0;
        k_sel  = 1'b0;
        abort  = 1'b0;
        vt[0] = '{1'b0, 0, 0};
        vt[1] = '{1'b0, 1, 83};
        vt[2] = '{1'b0, 2, 298};
        vt[3] = '{1'b0, 3, 645};
        vt[4] = '{1'b0, 1055, 49};
        vt[5] = '{1'b1, 0, 0};
        vt[6] = '{1'b1, 1, 743};
        vt[7] = '{1'b1, 2, 2446};
        vt[8] = '{1'b1, 6143, 217};

        tick();
        tick();
        all_zero("reset");
        aclr_n = 1'b1;

        run_block(1'b0, 1'b0, 1'b0, 3);
        run_block(1'b0, 1'b1, 1'b0, 5);
`ifdef TSCHED_OVERRUN_EN
        chk("overrun", overrun, 1);
        chk("ovr_cnt", ovr_cnt, 2);
`endif

        // Abort mid-ENC
        tick();
        start = 1'b1;
        k_sel = 1'b0;
        for (int c = 1; c <= 701; c++) begin
            tick();
            start = 1'b0;
        end
        chk("abort pre addr_nat", addr_nat, 700);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort busy", busy, 0);
        chk("abort rd_en", rd_en, 0);
        chk("abort enc_bit_vld", enc_bit_vld, 0);
        dcnt = 0;
        bcnt = 0;
        for (int c = 0; c < 1200; c++) begin
            tick();
            dcnt += int'(done);
            bcnt += int'(busy);
        end
        chk("abort no done", dcnt, 0);
        chk("abort stays idle", bcnt, 0);

        // start together with abort in IDLE
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("start+abort busy", busy, 0);
        chk("start+abort rd_en", rd_en, 0);

        // Reset during TAIL
        tick();
        start = 1'b1;
        k_sel = 1'b0;
        for (int c = 1; c <= 1056 + 2; c++) begin
            tick();
            start = 1'b0;
        end
        chk("pre-reset enc_tail", enc_tail, 1);
        aclr_n = 1'b0;
        tick();
        all_zero("reset in tail");
        aclr_n = 1'b1;

        run_block(1'b0, 1'b0, 1'b0, 2);
        run_block(1'b1, 1'b0, 1'b0, 2);

        // Back-to-back: second start lands in the first IDLE cycle after done
        run_block(1'b0, 1'b0, 1'b0, 0);
        run_block(1'b1, 1'b0, 1'b0, 4);

        // Random k_sel, random ignored starts, random gaps
        for (int b = 0; b < 3; b++) begin
            repeat ($urandom_range(0, 5)) tick();
            run_block(1'($urandom), 1'b0, 1'b1, 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
